bcd_disp_scan: RTL and testbench



---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_disp_scan_if.sv | 20 ++
 rtl/bcd_seg_decode.sv | 32 +++
 rtl/bcd_disp_scan.sv | 119 +++++++++++
 tb/tb_bcd_disp_scan.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the packed-BCD seven-segment display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam int BCD_DIGITS = 3;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam digit_idx_t IDX_ONES     = 2'd0;
  localparam digit_idx_t IDX_TENS     = 2'd1;
  localparam digit_idx_t IDX_HUNDREDS = 2'd2;

  function automatic logic [BCD_DIGITS-1:0] digit_onehot(input digit_idx_t i);
    logic [BCD_DIGITS-1:0] oh;
    oh = '0;
    case (i)
      IDX_ONES:     oh = 3'b001;
      IDX_TENS:     oh = 3'b010;
      IDX_HUNDREDS: oh = 3'b100;
      default:      oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bcd_disp_scan_if.sv
// Display-side bus: BCD word in with load strobe and blanking control,
// multiplexed segment/digit drive and error flag out.
interface bcd_disp_scan_if;
  logic [11:0] Bcd_in;
  logic        Load;
  logic        Blank_en;
  logic [6:0]  Seg;
  logic [2:0]  Dig_sel;
  logic        Err;

  modport master (
    output Bcd_in, Load, Blank_en,
    input  Seg, Dig_sel, Err
  );

  modport slave (
    input  Bcd_in, Load, Blank_en,
    output Seg, Dig_sel, Err
  );
endinterface

// File: rtl/bcd_seg_decode.sv
// One BCD nibble to an active-high seven-segment pattern.
// Invalid nibbles always show "E"; blanking applies to valid nibbles only.
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    invalid = (nibble > 4'd9);
    seg     = SEG_E;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
    if (blank && !invalid)
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/bcd_disp_scan.sv
// Three-digit multiplexed seven-segment driver with frame-synchronous update,
// leading-zero blanking and invalid-digit detection.
module bcd_disp_scan
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic            Clk,
  input  logic            Rst,
  bcd_disp_scan_if.slave  bus
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]      DIG_OFF    = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [11:0]   pending;
  logic          pending_vld;
  logic [11:0]   disp;
  logic          tc;
  logic          fw;

  assign tc = (presc == PRESC_LAST);
  assign fw = tc && (idx == IDX_HUNDREDS);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc <= '0;
      idx   <= IDX_ONES;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == IDX_HUNDREDS) ? IDX_ONES : idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // disp only moves at the frame wrap so a frame never mixes two words;
  // a Load on the wrap edge itself goes straight to disp.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending     <= '0;
      pending_vld <= 1'b0;
      disp        <= '0;
    end else if (fw) begin
      pending_vld <= 1'b0;
      if (bus.Load)
        disp <= bus.Bcd_in;
      else if (pending_vld)
        disp <= pending;
    end else if (bus.Load) begin
      pending     <= bus.Bcd_in;
      pending_vld <= 1'b1;
    end
  end

  logic [3:0] nib     [BCD_DIGITS];
  logic       blank_d [BCD_DIGITS];
  logic [6:0] pat     [BCD_DIGITS];
  logic       bad     [BCD_DIGITS];

  always_comb begin
    nib[0]     = disp[3:0];
    nib[1]     = disp[7:4];
    nib[2]     = disp[11:8];
    blank_d[0] = 1'b0;
    blank_d[1] = bus.Blank_en && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
    blank_d[2] = bus.Blank_en && (disp[11:8] == 4'd0);
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dec
    bcd_seg_decode u_dec (
      .nibble  (nib[g]),
      .blank   (blank_d[g]),
      .seg     (pat[g]),
      .invalid (bad[g])
    );
  end

  logic [6:0] seg_cur;
  logic       err_cur;

  always_comb begin
    seg_cur = SEG_BLANK;
    case (idx)
      IDX_ONES:     seg_cur = pat[0];
      IDX_TENS:     seg_cur = pat[1];
      IDX_HUNDREDS: seg_cur = pat[2];
      default:      seg_cur = SEG_BLANK;
    endcase
    err_cur = bad[0] | bad[1] | bad[2];
  end

  logic [6:0] seg_q;
  logic [2:0] dig_q;
  logic       err_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_cur ^ SEG_OFF;
      dig_q <= digit_onehot(idx) ^ DIG_OFF;
      err_q <= err_cur;
    end
  end

  assign bus.Seg     = seg_q;
  assign bus.Dig_sel = dig_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Scoreboard bench: stimulus pushes the expected registered outputs for each
// edge, a monitor pops and compares one entry per clock.
module tb_bcd_disp_scan;
  import bcd_pkg::*;

  localparam int DIV  = 4;
  localparam int FRAME = 3 * DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] dig;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_disp_scan_if bus ();

  bcd_disp_scan #(
    .SCAN_DIV       (DIV),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          started = 1'b0;

  // Reference model: time since reset release, word on display, pending word.
  int          m_k = 0;
  logic [11:0] m_disp = '0;
  logic [11:0] m_pend = '0;
  bit          m_pvld = 1'b0;

  function automatic exp_t predict(input logic [11:0] d, input int slot, input bit blank_en);
    exp_t e;
    int h, t, o, n;
    bit blanked;
    h = int'(d[11:8]);
    t = int'(d[7:4]);
    o = int'(d[3:0]);
    n = (slot == 0) ? o : (slot == 1) ? t : h;
    blanked = blank_en && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0));
    if (n > 9)        e.seg = 7'h79;
    else if (blanked) e.seg = 7'h00;
    else              e.seg = seg_tbl[n];
    e.dig = 3'(1 << slot);
    e.err = (h > 9) || (t > 9) || (o > 9);
    return e;
  endfunction

  task automatic tick(input bit r, input bit ld, input logic [11:0] bcd, input bit blank);
    exp_t e;
    int slot;
    bit fw;
    @(negedge clk);
    rst          = r;
    bus.Load     = ld;
    bus.Bcd_in   = bcd;
    bus.Blank_en = blank;
    if (r) begin
      e = '0;
      m_k = 0;
      m_disp = '0;
      m_pend = '0;
      m_pvld = 1'b0;
    end else begin
      slot = (m_k / DIV) % 3;
      fw   = (m_k % FRAME) == FRAME - 1;
      e    = predict(m_disp, slot, blank);
      if (fw) begin
        if (ld)          m_disp = bcd;
        else if (m_pvld) m_disp = m_pend;
        m_pvld = 1'b0;
      end else if (ld) begin
        m_pend = bcd;
        m_pvld = 1'b1;
      end
      m_k++;
    end
    q.push_back(e);
    started = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit blank);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 12'h000, blank);
  endtask

  task automatic load(input logic [11:0] bcd, input bit blank);
    tick(1'b0, 1'b1, bcd, blank);
  endtask

  task automatic to_fw(input bit blank);
    while ((m_k % FRAME) != FRAME - 1) tick(1'b0, 1'b0, 12'h000, blank);
  endtask

  task automatic to_slot(input int s, input bit blank);
    while (((m_k / DIV) % 3) != s) tick(1'b0, 1'b0, 12'h000, blank);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (started) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = q.pop_front();
        if (bus.Seg !== e.seg || bus.Dig_sel !== e.dig || bus.Err !== e.err) begin
          n_bad++;
          $display("FAIL outputs at %0t: got seg=%h dig=%b err=%b, want seg=%h dig=%b err=%b",
                   $time, bus.Seg, bus.Dig_sel, bus.Err, e.seg, e.dig, e.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    bus.Load     = 1'b0;
    bus.Bcd_in   = '0;
    bus.Blank_en = 1'b0;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 12'h000, 1'b0);
    idle(14, 1'b0);

    load(12'h123, 1'b0);
    idle(2 * FRAME + 3, 1'b0);

    load(12'h007, 1'b1);
    idle(2 * FRAME, 1'b1);
    idle(FRAME, 1'b0);

    load(12'h1A5, 1'b0);
    idle(2 * FRAME, 1'b0);
    load(12'h105, 1'b0);
    idle(2 * FRAME, 1'b0);

    to_fw(1'b0);
    idle(1, 1'b0);
    load(12'h111, 1'b0);
    idle(2, 1'b0);
    load(12'h222, 1'b0);
    idle(FRAME, 1'b0);
    to_fw(1'b0);
    load(12'h333, 1'b0);
    idle(2 * FRAME, 1'b0);

    load(12'h999, 1'b1);
    idle(FRAME + 2, 1'b1);
    to_slot(1, 1'b1);
    idle(1, 1'b1);
    tick(1'b1, 1'b0, 12'h000, 1'b1);
    idle(2 * FRAME, 1'b0);
    idle(FRAME, 1'b1);

    for (int i = 0; i < 600; i++) begin
      bit r, ld, bl;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 5) == 0);
      bl = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0)
        w = 12'($urandom_range(0, 4095));
      else
        w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) w[11:8] = 4'd0;
      if ($urandom_range(0, 3) == 0) w[7:4]  = 4'd0;
      tick(r, ld, w, bl);
    end
    idle(FRAME, 1'b0);

    #2;
    started = 1'b0;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
